// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM sequencer giving VGA scanout priority with a bounded CPU wait
module vram_arbiter #(
  parameter int ADDR_W        = 15,
  parameter int DATA_W        = 32,
  parameter int RAM_LATENCY   = 1,
  parameter int VGA_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vram_cpu_addr,
  input  logic [DATA_W-1:0] vram_cpu_data_out,
  input  logic              vram_cpu_req,
  input  logic              vram_cpu_write,
  output logic [DATA_W-1:0] vram_cpu_data_in,
  output logic              vram_cpu_ready,
  output logic              vram_cpu_done,
  input  logic [ADDR_W-1:0] vram_vga_addr,
  input  logic              vram_vga_req,
  output logic [DATA_W-1:0] vram_vga_data_out,
  output logic              vram_vga_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [3:0] BURST_MAX = 4'(VGA_BURST_MAX);
  localparam logic [1:0] LAT = 2'(RAM_LATENCY);
  logic [1:0] state;
  logic [1:0] lat_cnt;
  logic [3:0] burst_cnt;
  logic live;
  logic cpu_armed;
  logic vga_armed;
  logic owner_cpu;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic idle;
  logic cpu_elig;
  logic vga_elig;
  logic grant_cpu;
  logic grant_vga;
  // Eligibility and grant selection; the CPU wins only once VGA has used up its burst allowance
  always_comb begin
    idle = state == IDLE;
    cpu_elig = vram_cpu_req & cpu_armed;
    vga_elig = vram_vga_req & vga_armed;
    grant_cpu = idle & cpu_elig & ((burst_cnt == BURST_MAX) | ~vga_elig);
    grant_vga = idle & vga_elig & ~grant_cpu;
  end
  // Arming, burst accounting and the GRANT/WAIT/DONE access sequence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lat_cnt <= '0;
      burst_cnt <= '0;
      live <= 1'b0;
      cpu_armed <= 1'b0;
      vga_armed <= 1'b0;
      owner_cpu <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      vram_cpu_data_in <= '0;
      vram_vga_data_out <= '0;
    end else begin
      live <= 1'b1;
      cpu_armed <= ~vram_cpu_req | (cpu_armed & ~grant_cpu);
      vga_armed <= ~vram_vga_req | (vga_armed & ~grant_vga);
      if (idle)
        burst_cnt <= (grant_cpu | ~cpu_elig) ? 4'd0 :
                     (grant_vga & (burst_cnt != BURST_MAX)) ? burst_cnt + 4'd1 : burst_cnt;
      if (grant_cpu | grant_vga) begin
        state <= GRANT;
        owner_cpu <= grant_cpu;
        we_q <= grant_cpu & vram_cpu_write;
        addr_q <= grant_cpu ? vram_cpu_addr : vram_vga_addr;
        wdata_q <= vram_cpu_data_out;
      end
      if (state == GRANT) begin
        state <= we_q ? DONE : WAIT;
        lat_cnt <= 2'd1;
      end
      if (state == WAIT) begin
        lat_cnt <= lat_cnt + 2'd1;
        if (lat_cnt == LAT) begin
          state <= DONE;
          if (owner_cpu) vram_cpu_data_in <= ram_rdata;
          else vram_vga_data_out <= ram_rdata;
        end
      end
      if (state == DONE) state <= IDLE;
    end
  end
  assign vram_cpu_ready = live & idle;
  assign vram_cpu_done = (state == DONE) & owner_cpu;
  assign vram_vga_ready = (state == DONE) & ~owner_cpu;
  assign ram_en = state == GRANT;
  assign ram_we = ram_en & we_q;
  assign ram_addr = addr_q;
  assign ram_wdata = wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of the VRAM arbiter against a transaction-level model
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic rst_n [2];
  logic [14:0] cpu_addr [2];
  logic [14:0] vga_addr [2];
  logic [14:0] ram_addr [2];
  logic [31:0] cpu_wdata [2];
  logic [31:0] cpu_rdata [2];
  logic [31:0] vga_rdata [2];
  logic [31:0] ram_wdata [2];
  logic [31:0] ram_rdata [2];
  logic cpu_req [2];
  logic cpu_write [2];
  logic cpu_ready [2];
  logic cpu_done [2];
  logic vga_req [2];
  logic vga_ready [2];
  logic ram_en [2];
  logic ram_we [2];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int en_cnt [2];
  int en_cyc [2];
  logic [14:0] en_addr [2];
  logic en_we [2];
  logic [31:0] en_wd [2];
  string order [2];

  // Background contents of the memory: one marked word, the rest tagged by address
  function automatic logic [31:0] f(input logic [14:0] a);
    return a == 15'h123 ? 32'hDEADBEEF : {16'hCAFE, 1'b0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] ram [32768];
    logic [31:0] mm [32768];
    logic [31:0] pipe [3];
    int k;
    int burst;
    int last;
    logic oc, mw, ac, av, live, ec, ev, gc, gv;
    logic [14:0] ma;
    logic [31:0] mwd, mrd, xc, xv;

    vram_arbiter #(.RAM_LATENCY(L), .VGA_BURST_MAX(4)) dut (
      .clk(clk), .reset_n(rst_n[g]),
      .vram_cpu_addr(cpu_addr[g]), .vram_cpu_data_out(cpu_wdata[g]), .vram_cpu_req(cpu_req[g]),
      .vram_cpu_write(cpu_write[g]), .vram_cpu_data_in(cpu_rdata[g]), .vram_cpu_ready(cpu_ready[g]),
      .vram_cpu_done(cpu_done[g]), .vram_vga_addr(vga_addr[g]), .vram_vga_req(vga_req[g]),
      .vram_vga_data_out(vga_rdata[g]), .vram_vga_ready(vga_ready[g]),
      .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g]));

    initial for (int a = 0; a < 32768; a++) begin
      ram[a] = f(15'(a));
      mm[a] = f(15'(a));
    end

    // RAM macro: reads appear L cycles after the strobe; idle cycles return garbage
    always @(posedge clk) begin
      if (ram_en[g] && ram_we[g]) ram[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= (ram_en[g] && !ram_we[g]) ? ram[ram_addr[g]] : 32'hBADC0FFE;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_rdata[g] = pipe[L-1];

    // Model: k counts cycles since the grant decision; an access ends at cycle 2 (write) or 2+L (read)
    assign last = mw ? 2 : 2 + L;
    assign ec = cpu_req[g] && ac;
    assign ev = vga_req[g] && av;
    assign gc = k == 0 && ec && (burst == 4 || !ev);
    assign gv = k == 0 && ev && !gc;
    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        k <= 0; burst <= 0; live <= 1'b0; ac <= 1'b0; av <= 1'b0;
        oc <= 1'b0; mw <= 1'b0; ma <= '0; mwd <= '0; xc <= '0; xv <= '0;
      end else begin
        live <= 1'b1;
        ac <= !cpu_req[g] || (ac && !gc);
        av <= !vga_req[g] || (av && !gv);
        if (k == 0) burst <= (gc || !ec) ? 0 : (gv && burst < 4) ? burst + 1 : burst;
        if (gc || gv) begin
          k <= 1;
          oc <= gc;
          mw <= gc && cpu_write[g];
          ma <= gc ? cpu_addr[g] : vga_addr[g];
          mwd <= cpu_wdata[g];
          mrd <= mm[gc ? cpu_addr[g] : vga_addr[g]];
          if (gc && cpu_write[g]) mm[cpu_addr[g]] <= cpu_wdata[g];
        end else if (k != 0) k <= (k == last) ? 0 : k + 1;
        if (k != 0 && k + 1 == last && !mw) begin
          if (oc) xc <= mrd;
          else xv <= mrd;
        end
      end
    end

    // Per-cycle comparison against the model plus bookkeeping for the directed checks
    always @(negedge clk) begin
      chk($sformatf("u%0d ready/done/vready/en/we", g),
          {27'd0, cpu_ready[g], cpu_done[g], vga_ready[g], ram_en[g], ram_we[g]},
          {27'd0, live && k == 0, k != 0 && k == last && oc, k != 0 && k == last && !oc, k == 1, k == 1 && mw});
      chk($sformatf("u%0d cpu_data_in", g), cpu_rdata[g], xc);
      chk($sformatf("u%0d vga_data_out", g), vga_rdata[g], xv);
      if (ram_en[g] || !rst_n[g]) chk($sformatf("u%0d ram_addr", g), {17'd0, ram_addr[g]}, rst_n[g] ? {17'd0, ma} : 32'd0);
      if (ram_we[g] || !rst_n[g]) chk($sformatf("u%0d ram_wdata", g), ram_wdata[g], rst_n[g] ? mwd : 32'd0);
      if (ram_en[g]) begin
        en_cnt[g] <= en_cnt[g] + 1;
        en_cyc[g] <= cyc;
        en_addr[g] <= ram_addr[g];
        en_we[g] <= ram_we[g];
        en_wd[g] <= ram_wdata[g];
      end
      if (cpu_done[g]) order[g] <= {order[g], "C"};
      if (vga_ready[g]) order[g] <= {order[g], "V"};
    end
  end

  task automatic cpu_issue(input int i, input logic [14:0] a, input logic w, input logic [31:0] d, output int dc);
    cpu_addr[i] = a; cpu_write[i] = w; cpu_wdata[i] = d; cpu_req[i] = 1'b1; dc = -1;
    for (int n = 0; n < 100 && dc < 0; n++) begin
      @(negedge clk);
      if (cpu_done[i]) dc = cyc;
    end
    cpu_req[i] = 1'b0;
    chk("cpu_done within budget", 32'(dc >= 0), 32'd1);
  endtask

  task automatic vga_issue(input int i, input logic [14:0] a, output int dc);
    vga_addr[i] = a; vga_req[i] = 1'b1; dc = -1;
    for (int n = 0; n < 100 && dc < 0; n++) begin
      @(negedge clk);
      if (vga_ready[i]) dc = cyc;
    end
    vga_req[i] = 1'b0;
    chk("vga_ready within budget", 32'(dc >= 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0, dc, dv, d1, d2;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; cpu_req[i] = 1'b0; vga_req[i] = 1'b0; cpu_write[i] = 1'b0;
      cpu_addr[i] = '0; vga_addr[i] = '0; cpu_wdata[i] = '0;
      en_cnt[i] = 0; en_cyc[i] = 0; order[i] = "";
    end
    repeat (3) @(negedge clk);
    chk("reset cpu_ready", 32'(cpu_ready[0]), 32'd0);
    chk("reset ram_en", 32'(ram_en[0]), 32'd0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    #1 chk("cpu_ready before first edge", 32'(cpu_ready[0]), 32'd0);
    @(posedge clk); #1;
    chk("cpu_ready after first edge", 32'(cpu_ready[0]), 32'd1);
    @(posedge clk); #1;
    // Latency-3 instance: read, write, then VGA read of the written word
    c0 = cyc; e0 = en_cnt[1];
    cpu_issue(1, 15'h777, 1'b0, 32'd0, dc);
    chk("L3 read done cycle", dc - c0, 32'd5);
    chk("L3 read ram_en cycle", en_cyc[1] - c0, 32'd1);
    chk("L3 single ram_en", en_cnt[1] - e0, 32'd1);
    chk("L3 read data", cpu_rdata[1], 32'hCAFE0777);
    @(posedge clk); #1; c0 = cyc;
    cpu_issue(1, 15'h777, 1'b1, 32'h12345678, dc);
    chk("L3 write done cycle", dc - c0, 32'd2);
    @(posedge clk); #1; c0 = cyc;
    vga_issue(1, 15'h777, dc);
    chk("L3 vga ready cycle", dc - c0, 32'd5);
    chk("L3 vga data", vga_rdata[1], 32'h12345678);
    // VGA read of the marked word
    @(posedge clk); #1; c0 = cyc; e0 = en_cnt[0];
    vga_issue(0, 15'h123, dc);
    chk("vga ready cycle", dc - c0, 32'd3);
    chk("vga data", vga_rdata[0], 32'hDEADBEEF);
    chk("vga ram_en cycle", en_cyc[0] - c0, 32'd1);
    chk("vga ram_addr", {17'd0, en_addr[0]}, 32'h123);
    chk("vga single ram_en", en_cnt[0] - e0, 32'd1);
    // CPU write
    @(posedge clk); #1; c0 = cyc;
    cpu_issue(0, 15'h1234, 1'b1, 32'hA5A5A5A5, dc);
    chk("write done cycle", dc - c0, 32'd2);
    chk("write ram_en cycle", en_cyc[0] - c0, 32'd1);
    chk("write ram_we", 32'(en_we[0]), 32'd1);
    chk("write ram_addr", {17'd0, en_addr[0]}, 32'h1234);
    chk("write ram_wdata", en_wd[0], 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("memory after write", mdl[0].ram[15'h1234], 32'hA5A5A5A5);
    // Simultaneous first requests: VGA first, CPU next
    c0 = cyc;
    fork
      cpu_issue(0, 15'h10, 1'b0, 32'd0, dc);
      vga_issue(0, 15'h20, dv);
    join
    chk("simul vga ready cycle", dv - c0, 32'd3);
    chk("simul cpu done cycle", dc - c0, 32'd7);
    chk("simul cpu data", cpu_rdata[0], 32'hCAFE0010);
    chk("simul vga data", vga_rdata[0], 32'hCAFE0020);
    // Starvation bound: continuous VGA stream against two back-to-back CPU reads
    @(posedge clk); #1; c0 = cyc; order[0] = "";
    fork
      for (int n = 0; n < 10; n++) begin
        vga_issue(0, 15'h100 + 15'(n), dv);
        @(posedge clk); #1;
      end
      begin
        cpu_issue(0, 15'h40, 1'b0, 32'd0, d1);
        @(posedge clk); #1;
        cpu_issue(0, 15'h41, 1'b0, 32'd0, d2);
        @(posedge clk); #1;
      end
    join
    chk_s("burst grant order", order[0], "VVVVCVVVVCVV");
    chk("first starved cpu done", d1 - c0, 32'd19);
    chk("second starved cpu done", d2 - c0, 32'd39);
    // Reset during WAIT with the request held high
    c0 = cyc; e0 = en_cnt[0];
    cpu_addr[0] = 15'h50; cpu_write[0] = 1'b0; cpu_req[0] = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    rst_n[0] = 1'b0;
    #1;
    chk("mid-reset ram_en", 32'(ram_en[0]), 32'd0);
    chk("mid-reset cpu_ready", 32'(cpu_ready[0]), 32'd0);
    chk("mid-reset cpu_data_in", cpu_rdata[0], 32'd0);
    chk("mid-reset vga_data_out", vga_rdata[0], 32'd0);
    chk("mid-reset ram_addr", {17'd0, ram_addr[0]}, 32'd0);
    repeat (2) @(posedge clk); #3;
    rst_n[0] = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("held req ignored after reset", en_cnt[0] - e0, 32'd1);
    cpu_req[0] = 1'b0;
    @(posedge clk); #1; c0 = cyc;
    cpu_issue(0, 15'h50, 1'b0, 32'd0, dc);
    chk("rearmed cpu done cycle", dc - c0, 32'd3);
    chk("rearmed ram_en count", en_cnt[0] - e0, 32'd2);
    chk("rearmed cpu data", cpu_rdata[0], 32'hCAFE0050);
    repeat (3) @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
